// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: FSM states and the
// bundle of PC / pipeline-register enables and flushes it drives.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic READ_ENABLE = 1'b1;

    typedef enum logic [1:0] {
        PIPE_RUN     = 2'd0,
        PIPE_FLUSH   = 2'd1,
        PIPE_WAIT_EX = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic id_ex_we;
        logic if_id_flush;
        logic id_ex_flush;
    } ctrl_t;

    // Canned control patterns: normal flow, freeze, wrong-path squash,
    // single load-use bubble, and the forced values held during reset.
    localparam ctrl_t CTRL_PASS   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t CTRL_SQUASH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam ctrl_t CTRL_BUBBLE = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard check between the instruction in ID and a load in EX.
// Purely combinational; x0 as destination never matches.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] idReadAddr1,
    input  logic [REG_ADDR_W-1:0] idReadAddr2,
    input  logic                  idReadEn1,
    input  logic                  idReadEn2,
    input  logic [REG_ADDR_W-1:0] exWriteAddr,
    input  logic                  exWriteEnable,
    input  logic                  exMemRead,
    output logic                  hz
);

    logic ex_load_vld;
    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        ex_load_vld = exMemRead & exWriteEnable & (exWriteAddr != '0);
        rs1_hit     = (idReadEn1 == READ_ENABLE) & (idReadAddr1 == exWriteAddr);
        rs2_hit     = (idReadEn2 == READ_ENABLE) & (idReadAddr2 == exWriteAddr);
        hz          = ex_load_vld & (rs1_hit | rs2_hit);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: load-use stalls, post-branch squash and
// multicycle-EX freeze; outputs react combinationally to the current inputs.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   resetIn,
    input  logic [REG_ADDR_W-1:0]  idReadAddr1,
    input  logic [REG_ADDR_W-1:0]  idReadAddr2,
    input  logic                   idReadEn1,
    input  logic                   idReadEn2,
    input  logic [REG_ADDR_W-1:0]  exWriteAddr,
    input  logic                   exWriteEnable,
    input  logic                   exMemRead,
    input  logic                   exBranchTaken,
    input  logic                   exBusy,
    output logic                   pcWriteEnable,
    output logic                   ifIdWriteEnable,
    output logic                   idExWriteEnable,
    output logic                   ifIdFlush,
    output logic                   idExFlush,
    output logic [1:0]             ctrlState,
    output logic [STALL_CNT_W-1:0] stallCount
);

    // The branch cycle itself is the first flush cycle, so the counter
    // only covers the extra cycles spent in FLUSH afterwards.
    localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);
    localparam logic [1:0] FLUSH_INIT  = 2'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);

    logic                   hz;
    ctrl_t                  ctrl;
    pipe_state_e            state_q,     state_d;
    logic [1:0]             flush_cnt_q, flush_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    hazard_detect u_hazard_detect (
        .idReadAddr1   (idReadAddr1),
        .idReadAddr2   (idReadAddr2),
        .idReadEn1     (idReadEn1),
        .idReadEn2     (idReadEn2),
        .exWriteAddr   (exWriteAddr),
        .exWriteEnable (exWriteEnable),
        .exMemRead     (exMemRead),
        .hz            (hz)
    );

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        ctrl        = CTRL_PASS;

        case (state_q)
            // WAIT_EX evaluates exactly like RUN: busy keeps it frozen, and
            // the release cycle honours any branch or hazard present.
            PIPE_RUN, PIPE_WAIT_EX: begin
                if (exBusy) begin
                    ctrl    = CTRL_FREEZE;
                    state_d = PIPE_WAIT_EX;
                end else if (exBranchTaken) begin
                    ctrl    = CTRL_SQUASH;
                    state_d = PIPE_RUN;
                    if (MULTI_FLUSH) begin
                        state_d     = PIPE_FLUSH;
                        flush_cnt_d = FLUSH_INIT;
                    end
                end else begin
                    state_d = PIPE_RUN;
                    if (hz) begin
                        ctrl = CTRL_BUBBLE;
                    end
                end
            end
            PIPE_FLUSH: begin
                ctrl = CTRL_SQUASH;
                if (flush_cnt_q == 2'd0) begin
                    state_d = PIPE_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 2'd1;
                end
            end
            default: begin
                ctrl    = CTRL_FREEZE;
                state_d = PIPE_RUN;
            end
        endcase

        if (!resetIn) begin
            ctrl = CTRL_RESET;
        end

        stall_cnt_d = stall_cnt_q;
        if (resetIn && !ctrl.pc_we && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetIn) begin
            state_q     <= PIPE_RUN;
            flush_cnt_q <= 2'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pcWriteEnable   = ctrl.pc_we;
    assign ifIdWriteEnable = ctrl.if_id_we;
    assign idExWriteEnable = ctrl.id_ex_we;
    assign ifIdFlush       = ctrl.if_id_flush;
    assign idExFlush       = ctrl.id_ex_flush;
    assign ctrlState       = state_q;
    assign stallCount      = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: a FLUSH_CYCLES=3/4-bit-counter instance and a
// FLUSH_CYCLES=1/16-bit-counter instance driven by the same stimulus.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       resetIn;
    logic [4:0] idReadAddr1, idReadAddr2, exWriteAddr;
    logic       idReadEn1, idReadEn2, exWriteEnable, exMemRead, exBranchTaken, exBusy;

    logic        pc_a, ifid_a, idex_a, iff_a, idf_a;
    logic [1:0]  st_a;
    logic [3:0]  cnt_a;
    logic        pc_b, ifid_b, idex_b, iff_b, idf_b;
    logic [1:0]  st_b;
    logic [15:0] cnt_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.FLUSH_CYCLES(3), .STALL_CNT_W(4)) u_dut_a (
        .clk(clk), .resetIn(resetIn),
        .idReadAddr1(idReadAddr1), .idReadAddr2(idReadAddr2),
        .idReadEn1(idReadEn1), .idReadEn2(idReadEn2),
        .exWriteAddr(exWriteAddr), .exWriteEnable(exWriteEnable),
        .exMemRead(exMemRead), .exBranchTaken(exBranchTaken), .exBusy(exBusy),
        .pcWriteEnable(pc_a), .ifIdWriteEnable(ifid_a), .idExWriteEnable(idex_a),
        .ifIdFlush(iff_a), .idExFlush(idf_a), .ctrlState(st_a), .stallCount(cnt_a)
    );

    pipe_ctrl #(.FLUSH_CYCLES(1), .STALL_CNT_W(16)) u_dut_b (
        .clk(clk), .resetIn(resetIn),
        .idReadAddr1(idReadAddr1), .idReadAddr2(idReadAddr2),
        .idReadEn1(idReadEn1), .idReadEn2(idReadEn2),
        .exWriteAddr(exWriteAddr), .exWriteEnable(exWriteEnable),
        .exMemRead(exMemRead), .exBranchTaken(exBranchTaken), .exBusy(exBusy),
        .pcWriteEnable(pc_b), .ifIdWriteEnable(ifid_b), .idExWriteEnable(idex_b),
        .ifIdFlush(iff_b), .idExFlush(idf_b), .ctrlState(st_b), .stallCount(cnt_b)
    );

    // {pcWriteEnable, ifIdWriteEnable, idExWriteEnable, ifIdFlush, idExFlush}
    function automatic logic [4:0] outs(input int d);
        return (d == 0) ? {pc_a, ifid_a, idex_a, iff_a, idf_a}
                        : {pc_b, ifid_b, idex_b, iff_b, idf_b};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        resetIn = 1'b1;
        idReadAddr1 = 5'd0; idReadAddr2 = 5'd0; exWriteAddr = 5'd0;
        idReadEn1 = 1'b0; idReadEn2 = 1'b0; exWriteEnable = 1'b0;
        exMemRead = 1'b0; exBranchTaken = 1'b0; exBusy = 1'b0;
    endtask

    // Returns one time unit after a posedge, with reset just released.
    task automatic do_reset(input int n);
        set_idle();
        resetIn = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        resetIn = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [4:0] a1, a2, wa;
        logic       en1, en2, we, mr, br, busy;
        logic [4:0] exp;
    } vec_t;

    // Reference model: flush modelled as "cycles still to squash" after the
    // current one; stall count as a plain saturating integer.
    int fc[2]     = '{3, 1};
    int smax[2]   = '{15, 65535};
    int m_frem[2];
    bit m_wait[2];
    int m_stall[2];

    function automatic bit model_hz();
        logic [4:0] rd_addr[2];
        bit         rd_used[2];
        bit         hit = 0;
        rd_addr = '{idReadAddr1, idReadAddr2};
        rd_used = '{idReadEn1, idReadEn2};
        if (exMemRead && exWriteEnable && exWriteAddr != 5'd0)
            foreach (rd_addr[k])
                if (rd_used[k] && rd_addr[k] == exWriteAddr) hit = 1;
        return hit;
    endfunction

    task automatic model_check(input int d);
        logic [4:0] exp;
        int         exp_state;
        exp_state = (m_frem[d] > 0) ? 1 : (m_wait[d] ? 2 : 0);
        chk($sformatf("rand_state_%0d", d), 32'((d == 0) ? st_a : st_b), 32'(exp_state));
        chk($sformatf("rand_stall_%0d", d), (d == 0) ? 32'(cnt_a) : 32'(cnt_b), 32'(m_stall[d]));
        if (!resetIn) begin
            exp = 5'b00011;
            m_frem[d] = 0; m_wait[d] = 0; m_stall[d] = 0;
        end else if (m_frem[d] > 0) begin
            exp = 5'b11111;
            m_frem[d]--;
        end else if (exBusy) begin
            exp = 5'b00000;
            m_wait[d] = 1;
        end else begin
            m_wait[d] = 0;
            if (exBranchTaken) begin
                exp = 5'b11111;
                m_frem[d] = fc[d] - 1;
            end else if (model_hz()) begin
                exp = 5'b00101;
            end else begin
                exp = 5'b11100;
            end
        end
        if (resetIn && !exp[4] && m_stall[d] < smax[d]) m_stall[d]++;
        chk($sformatf("rand_outs_%0d", d), 32'(outs(d)), 32'(exp));
    endtask

    initial begin
        vec_t vt[11];
        set_idle();
        resetIn = 1'b0;
        next_cycle();

        // Reset held with busy and branch asserted.
        exBusy = 1'b1; exBranchTaken = 1'b1; resetIn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_outs", 32'(outs(0)), 32'b00011);
            next_cycle();
        end
        set_idle();
        @(negedge clk);
        chk("reset_state", 32'(st_a), 32'd0);
        chk("reset_stall", 32'(cnt_a), 32'd0);
        chk("release_outs", 32'(outs(0)), 32'b11100);

        //            a1     a2     wa    en1   en2   we    mr    br    busy  exp
        vt[0]  = '{5'd0, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00101};
        vt[1]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b11100};
        vt[2]  = '{5'd0, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b11100};
        vt[3]  = '{5'd7, 5'd2, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00101};
        vt[4]  = '{5'd7, 5'd2, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11100};
        vt[5]  = '{5'd7, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'b11100};
        vt[6]  = '{5'd0, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'b00000};
        vt[7]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b11111};
        vt[8]  = '{5'd3, 5'd4, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'b11111};
        vt[9]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00000};
        vt[10] = '{5'd5, 5'd3, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b11100};
        foreach (vt[i]) begin
            do_reset(1);
            idReadAddr1 = vt[i].a1; idReadAddr2 = vt[i].a2; exWriteAddr = vt[i].wa;
            idReadEn1 = vt[i].en1; idReadEn2 = vt[i].en2; exWriteEnable = vt[i].we;
            exMemRead = vt[i].mr; exBranchTaken = vt[i].br; exBusy = vt[i].busy;
            @(negedge clk);
            chk($sformatf("vec%0d_a", i), 32'(outs(0)), 32'(vt[i].exp));
            chk($sformatf("vec%0d_b", i), 32'(outs(1)), 32'(vt[i].exp));
        end

        // Single-cycle load-use bubble.
        do_reset(2);
        exMemRead = 1'b1; exWriteEnable = 1'b1; exWriteAddr = 5'd5;
        idReadEn2 = 1'b1; idReadAddr2 = 5'd5;
        @(negedge clk);
        chk("lu_stall_outs", 32'(outs(0)), 32'b00101);
        next_cycle();
        set_idle();
        @(negedge clk);
        chk("lu_after_outs", 32'(outs(0)), 32'b11100);
        chk("lu_stall_cnt", 32'(cnt_a), 32'd1);

        // Branch: three flush cycles on A, spurious branch at t1 ignored.
        do_reset(2);
        exBranchTaken = 1'b1;
        @(negedge clk);
        chk("br_t0_iff", 32'(iff_a), 32'd1);
        chk("br_t0_state", 32'(st_a), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("br_t1_outs", 32'(outs(0)), 32'b11111);
        chk("br_t1_state", 32'(st_a), 32'd1);
        next_cycle();
        exBranchTaken = 1'b0;
        @(negedge clk);
        chk("br_t2_iff", 32'(iff_a), 32'd1);
        chk("br_t2_state", 32'(st_a), 32'd1);
        chk("br1_t2_iff", 32'(iff_b), 32'd0);
        chk("br1_t2_state", 32'(st_b), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("br_t3_iff", 32'(iff_a), 32'd0);
        chk("br_t3_state", 32'(st_a), 32'd0);
        chk("br_stall_cnt", 32'(cnt_a), 32'd0);

        // Multicycle freeze then release together with a branch.
        do_reset(2);
        exBusy = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            chk($sformatf("busy_t%0d_we", t), 32'(outs(0) >> 2), 32'd0);
            chk($sformatf("busy_t%0d_state", t), 32'(st_a), (t == 0) ? 32'd0 : 32'd2);
            next_cycle();
        end
        exBusy = 1'b0; exBranchTaken = 1'b1;
        @(negedge clk);
        chk("busy_t4_outs", 32'(outs(0)), 32'b11111);
        chk("busy_t4_stall", 32'(cnt_a), 32'd4);
        next_cycle();
        set_idle();
        @(negedge clk);
        chk("busy_t5_state", 32'(st_a), 32'd1);

        // Saturation of the 4-bit counter.
        do_reset(1);
        exBusy = 1'b1;
        repeat (20) next_cycle();
        @(negedge clk);
        chk("sat_a", 32'(cnt_a), 32'd15);
        chk("sat_b", 32'(cnt_b), 32'd20);
        next_cycle();
        @(negedge clk);
        chk("sat_a_hold", 32'(cnt_a), 32'd15);

        // Randomized run against the reference model.
        do_reset(2);
        foreach (m_frem[d]) begin
            m_frem[d] = 0; m_wait[d] = 0; m_stall[d] = 0;
        end
        for (int n = 0; n < 600; n++) begin
            resetIn       = ($urandom_range(0, 99) >= 3);
            idReadAddr1   = 5'($urandom_range(0, 3));
            idReadAddr2   = 5'($urandom_range(0, 3));
            exWriteAddr   = 5'($urandom_range(0, 3));
            idReadEn1     = 1'($urandom_range(0, 1));
            idReadEn2     = 1'($urandom_range(0, 1));
            exWriteEnable = ($urandom_range(0, 3) != 0);
            exMemRead     = 1'($urandom_range(0, 1));
            exBranchTaken = ($urandom_range(0, 99) < 15);
            exBusy        = ($urandom_range(0, 99) < 25);
            @(negedge clk);
            model_check(0);
            model_check(1);
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core. It sits between the decode stage, the IF/ID and ID/EX pipeline registers, and the EX stage.
- Detects load-use hazards on the register read addresses produced by the decoder.
- Squashes wrong-path instructions after a taken branch.
- Freezes the front end while a multicycle EX unit is busy.
- Owns the PC, IF/ID and ID/EX write-enable and flush controls, plus a saturating stall counter for performance monitoring.

Parameters:
- FLUSH_CYCLES, 1, total cycles IF/ID is flushed after a taken branch (covers instruction-fetch latency); legal range 1..4.
- STALL_CNT_W, 16, width of the stall performance counter.

Ports:
- clk  input  1  core clock, rising edge.
- resetIn  input  1  synchronous, active-low reset.
- idReadAddr1  input  5  decoder rs1 address (`RegAddrSize).
- idReadAddr2  input  5  decoder rs2 address.
- idReadEn1  input  1  rs1 actually used by the instruction in ID.
- idReadEn2  input  1  rs2 actually used by the instruction in ID.
- exWriteAddr  input  5  rd of the instruction in EX.
- exWriteEnable  input  1  instruction in EX writes rd.
- exMemRead  input  1  instruction in EX is a load.
- exBranchTaken  input  1  EX resolved a taken branch or jump this cycle.
- exBusy  input  1  multicycle EX unit has not finished.
- pcWriteEnable  output  1  PC may update.
- ifIdWriteEnable  output  1  IF/ID register may load.
- idExWriteEnable  output  1  ID/EX register may load.
- ifIdFlush  output  1  IF/ID loads a NOP.
- idExFlush  output  1  ID/EX loads a bubble (`NOP, writeEnable=`RegWriteDeny).
- ctrlState  output  2  current FSM state, for debug.
- stallCount  output  STALL_CNT_W  saturating count of cycles with pcWriteEnable=0.

Behaviour:
- The FSM state and counters are registered. Control outputs are combinational from the state and the current inputs (zero-latency reaction).
- States: RUN=2'd0, FLUSH=2'd1, WAIT_EX=2'd2. Encoding 2'd3 is illegal and recovers to RUN on the next edge.
- Reset (resetIn=0 at a posedge):
  - state=RUN, flushCnt=0, stallCount=0.
  - While resetIn=0, outputs are forced: pcWriteEnable=0, ifIdWriteEnable=0, idExWriteEnable=0, ifIdFlush=1, idExFlush=1.
  - Reset mid-flush or mid-wait abandons the sequence immediately.
  - Cycles spent in reset are not counted by stallCount.
- Load-use hazard definition: hz = exMemRead & exWriteEnable & (exWriteAddr!=0) & ((idReadEn1 & idReadAddr1==exWriteAddr) | (idReadEn2 & idReadAddr2==exWriteAddr)).
- Default outputs in RUN: pcWriteEnable=1, ifIdWriteEnable=1, idExWriteEnable=1, both flushes 0.
- Priority in RUN, highest first:
  1. exBusy=1:
     - pcWriteEnable=0, ifIdWriteEnable=0, idExWriteEnable=0, no flush.
     - exBranchTaken and hz are ignored.
     - Next state WAIT_EX.
  2. exBranchTaken=1:
     - pcWriteEnable=1 (PC loads the target), ifIdFlush=1, idExFlush=1.
     - If FLUSH_CYCLES>1: next state FLUSH, flushCnt=FLUSH_CYCLES-2. Otherwise stay in RUN.
  3. hz=1:
     - pcWriteEnable=0, ifIdWriteEnable=0, idExFlush=1 (one bubble).
     - Stay in RUN; on the next cycle the load has left EX, so hz clears.
- WAIT_EX:
  - Same outputs as RUN case 1 while exBusy=1.
  - In the cycle exBusy drops to 0, outputs revert to the RUN evaluation of that cycle (branch or hazard are honoured), and the next state is RUN, or FLUSH if the RUN evaluation requires it.
- FLUSH:
  - pcWriteEnable=1, ifIdWriteEnable=1, ifIdFlush=1, idExFlush=1.
  - exBranchTaken, exBusy and hz are ignored, since EX holds only bubbles.
  - If flushCnt==0, next state RUN; else flushCnt decrements.
- stallCount: +1 on every non-reset cycle with pcWriteEnable=0. Holds at all-ones; no wrap.
- exWriteAddr==0 never causes a hazard, because x0 is hardwired to zero.

Decomposition:
- Add to define.v: state encodings (`PipeRun, `PipeFlush, `PipeWaitEx) and `ReadEnable/`ReadDisable.
- Reuse the existing `RegAddrSize, `NOP and `RegWriteDeny.
- Hazard comparison goes in a combinational sub-module hazard_detect, with the idRead*, ex* inputs and an hz output. The FSM and counter stay in pipe_ctrl.

Test Plan:
- Reset: hold resetIn=0 for 3 cycles with exBusy=1 and exBranchTaken=1 → both flushes 1, all enables 0, stallCount=0, ctrlState=0. After release with idle inputs → enables 1, flushes 0.
- Load-use: exMemRead=1, exWriteEnable=1, exWriteAddr=5, idReadEn2=1, idReadAddr2=5 for 1 cycle → pcWriteEnable=0, ifIdWriteEnable=0, idExFlush=1 that cycle only; stallCount=1. The same stimulus with exWriteAddr=0, or with idReadEn2=0 → no stall.
- Branch with FLUSH_CYCLES=3: pulse exBranchTaken at t0 → ifIdFlush=1 at t0, t1 and t2, with ctrlState=1 during t1–t2; at t3 ifIdFlush=0 and ctrlState=0. A spurious exBranchTaken at t1 does not extend the flush.
- Multicycle: exBusy=1 for 4 cycles starting at t0 → pcWriteEnable, ifIdWriteEnable and idExWriteEnable are 0 for t0–t3, and ctrlState=2 during t1–t3. At t4 exBusy=0 together with exBranchTaken=1 → flush asserted at t4; stallCount=4.
- Priority: exBusy=1, exBranchTaken=1 and hz=1 together → the busy freeze applies and no flush is asserted.
- Saturation with STALL_CNT_W=4: hold exBusy for 20 cycles → stallCount=15 and stays 15.
